// File: rtl/oled_char_responder.sv
// OLED character responder: fetches 8 font columns per character write into a 4x128 page buffer
// and streams that buffer to the panel over a write-only SPI (mode 0) link. Optional macro OLED_INVERT_EN.
module oled_char_responder #(
    parameter int SCLK_DIV   = 4,
    parameter int PAGE_NUM   = 4,
    parameter int COLUMN_NUM = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_start,
    input  logic [7:0]  write_ascii_data,
    input  logic [8:0]  write_base_addr,
    output logic        write_ready,
    input  logic        update_start,
    input  logic        update_clear,
    output logic        update_ready,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        oled_sclk,
    output logic        oled_sdin,
    output logic        oled_dc
);

    localparam int COL_W  = 7;
    localparam int PAGE_W = 2;
    localparam int BUF_AW = PAGE_W + COL_W;
    localparam int IDX_W  = $clog2(COLUMN_NUM + 3);
    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(COLUMN_NUM + 2);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGE_NUM - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [7:0]        CMD_PAGE  = 8'hB0;
    localparam logic [7:0]        CMD_COLLO = 8'h00;
    localparam logic [7:0]        CMD_COLHI = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        WR_FETCH,
        UPD_SHIFT,
        UPD_NEXT
    } state_t;

    state_t              state_q;
    logic                ready_q;
    logic [7:0]          asciiCode_q;
    logic [8:0]          baseAddr_q;
    logic [3:0]          fetchCnt_q;
    logic [10:0]         fontAddr_q;
    logic                clr_q;
    logic [PAGE_W-1:0]   page_q;
    logic [IDX_W-1:0]    byteIdx_q;
    logic [2:0]          bitCnt_q;
    logic [DIV_W-1:0]    divCnt_q;
    logic [7:0]          shift_q;
    logic                sclk_q;
    logic                sdin_q;
    logic                dc_q;

    logic [7:0]          pageBuf [PAGE_NUM*COLUMN_NUM];

    logic                wrEn;
    logic [COL_W-1:0]    wrCol;
    logic [BUF_AW-1:0]   wrAddr;
    logic                lastInPage;
    logic                lastByte;
    logic [PAGE_W-1:0]   nextPage_d;
    logic [IDX_W-1:0]    nextIdx_d;
    logic [BUF_AW-1:0]   rdAddr;
    logic [7:0]          dataByte;
    logic [7:0]          loadByte_d;
    logic                loadDc_d;
    logic                divDone;

    // Stores trail the font address by one cycle; the column wraps inside the page.
    always_comb begin
        wrEn   = (state_q == WR_FETCH) && (fetchCnt_q != 4'd0);
        wrCol  = baseAddr_q[6:0] + COL_W'(fetchCnt_q - 4'd1);
        wrAddr = {baseAddr_q[8:7], wrCol};
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            pageBuf[wrAddr] <= font_data;
        end
    end

    // Next byte of the update stream, prepared so it can be loaded with no gap cycle.
    always_comb begin
        lastInPage = (byteIdx_q == LAST_IDX);
        lastByte   = lastInPage && (page_q == LAST_PAGE);
        nextPage_d = lastInPage ? page_q + 1'b1 : page_q;
        nextIdx_d  = lastInPage ? '0 : byteIdx_q + 1'b1;
        rdAddr     = {nextPage_d, COL_W'(nextIdx_d - IDX_W'(3))};
        dataByte   = clr_q ? 8'h00 : pageBuf[rdAddr];
`ifdef OLED_INVERT_EN
        dataByte   = ~dataByte;
`endif
        loadDc_d   = 1'b1;
        loadByte_d = dataByte;
        if (nextIdx_d == IDX_W'(0)) begin
            loadDc_d   = 1'b0;
            loadByte_d = CMD_PAGE | {{(8-PAGE_W){1'b0}}, nextPage_d};
        end else if (nextIdx_d == IDX_W'(1)) begin
            loadDc_d   = 1'b0;
            loadByte_d = CMD_COLLO;
        end else if (nextIdx_d == IDX_W'(2)) begin
            loadDc_d   = 1'b0;
            loadByte_d = CMD_COLHI;
        end
        divDone = (divCnt_q == DIV_LAST);
    end

    // UPD_SHIFT is the SCLK-low half of a bit, UPD_NEXT the high half that advances bit/byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            asciiCode_q <= '0;
            baseAddr_q  <= '0;
            fetchCnt_q  <= '0;
            fontAddr_q  <= '0;
            clr_q       <= 1'b0;
            page_q      <= '0;
            byteIdx_q   <= '0;
            bitCnt_q    <= '0;
            divCnt_q    <= '0;
            shift_q     <= '0;
            sclk_q      <= 1'b0;
            sdin_q      <= 1'b0;
            dc_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (write_start) begin
                        asciiCode_q <= write_ascii_data;
                        baseAddr_q  <= write_base_addr;
                        fetchCnt_q  <= '0;
                        fontAddr_q  <= {write_ascii_data, 3'd0};
                        ready_q     <= 1'b0;
                        state_q     <= WR_FETCH;
                    end else if (update_start) begin
                        clr_q     <= update_clear;
                        page_q    <= '0;
                        byteIdx_q <= '0;
                        bitCnt_q  <= '0;
                        divCnt_q  <= '0;
                        dc_q      <= 1'b0;
                        sdin_q    <= CMD_PAGE[7];
                        shift_q   <= {CMD_PAGE[6:0], 1'b0};
                        sclk_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        state_q   <= UPD_SHIFT;
                    end
                end

                WR_FETCH: begin
                    fetchCnt_q <= fetchCnt_q + 4'd1;
                    if (fetchCnt_q < 4'd7) begin
                        fontAddr_q <= {asciiCode_q, fetchCnt_q[2:0] + 3'd1};
                    end
                    if (fetchCnt_q == 4'd8) begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end

                UPD_SHIFT: begin
                    if (divDone) begin
                        divCnt_q <= '0;
                        sclk_q   <= 1'b1;
                        state_q  <= UPD_NEXT;
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end

                UPD_NEXT: begin
                    if (divDone) begin
                        divCnt_q <= '0;
                        sclk_q   <= 1'b0;
                        if (bitCnt_q != 3'd7) begin
                            bitCnt_q <= bitCnt_q + 3'd1;
                            sdin_q   <= shift_q[7];
                            shift_q  <= {shift_q[6:0], 1'b0};
                            state_q  <= UPD_SHIFT;
                        end else if (lastByte) begin
                            bitCnt_q <= '0;
                            sdin_q   <= 1'b0;
                            dc_q     <= 1'b0;
                            ready_q  <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            bitCnt_q  <= '0;
                            page_q    <= nextPage_d;
                            byteIdx_q <= nextIdx_d;
                            dc_q      <= loadDc_d;
                            sdin_q    <= loadByte_d[7];
                            shift_q   <= {loadByte_d[6:0], 1'b0};
                            state_q   <= UPD_SHIFT;
                        end
                    end else begin
                        divCnt_q <= divCnt_q + 1'b1;
                    end
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign write_ready  = ready_q;
    assign update_ready = ready_q;
    assign font_addr    = fontAddr_q;
    assign oled_sclk    = sclk_q;
    assign oled_sdin    = sdin_q;
    assign oled_dc      = dc_q;

endmodule

// File: tb/tb_oled_char_responder.sv
// Bench for oled_char_responder: random character writes tracked in a flat byte model of the
// display, SPI stream decoded on rising SCLK and compared against that model.
module tb_oled_char_responder;

    localparam int PAGES      = 4;
    localparam int COLS       = 128;
    localparam int PAGE_BYTES = COLS + 3;
    localparam int UPD_BYTES  = PAGES * PAGE_BYTES;
    localparam int UPD_CYCLES = UPD_BYTES * 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_start = 1'b0;
    logic [7:0]  write_ascii_data = '0;
    logic [8:0]  write_base_addr = '0;
    logic        update_start = 1'b0;
    logic        update_clear = 1'b0;
    logic        write_ready;
    logic        update_ready;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic        oled_sclk;
    logic        oled_sdin;
    logic        oled_dc;

    int checks = 0;
    int errors = 0;

    logic [7:0] model [PAGES*COLS];

    logic [8:0] capQ [$];
    int         monBits = 0;
    logic [7:0] monByte = '0;
    logic       monDc = 1'b0;
    int         dcHoldErrs = 0;
    int         sclkRises = 0;

    oled_char_responder #(
        .SCLK_DIV   (1),
        .PAGE_NUM   (PAGES),
        .COLUMN_NUM (COLS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .write_start      (write_start),
        .write_ascii_data (write_ascii_data),
        .write_base_addr  (write_base_addr),
        .write_ready      (write_ready),
        .update_start     (update_start),
        .update_clear     (update_clear),
        .update_ready     (update_ready),
        .font_addr        (font_addr),
        .font_data        (font_data),
        .oled_sclk        (oled_sclk),
        .oled_sdin        (oled_sdin),
        .oled_dc          (oled_dc)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM whose contents are simply the low address byte.
    always @(posedge clk) font_data <= font_addr[7:0];

    // Panel side: shift in one bit per rising SCLK, dc must stay put across a byte.
    always @(posedge oled_sclk or posedge rst) begin
        if (rst) begin
            monBits = 0;
        end else begin
            sclkRises++;
            if (monBits == 0) monDc = oled_dc;
            else if (oled_dc !== monDc) dcHoldErrs++;
            monByte = {monByte[6:0], oled_sdin};
            monBits++;
            if (monBits == 8) begin
                capQ.push_back({monDc, monByte});
                monBits = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] dataExp(input logic [7:0] v);
`ifdef OLED_INVERT_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ws, input logic [7:0] ascii, input logic [8:0] addr,
                                 input logic us, input logic uc);
        @(negedge clk);
        write_start      = ws;
        write_ascii_data = ascii;
        write_base_addr  = addr;
        update_start     = us;
        update_clear     = uc;
        @(posedge clk);
        #1;
        write_start  = 1'b0;
        update_start = 1'b0;
        update_clear = 1'b0;
    endtask

    task automatic doWrite(input logic [7:0] ascii, input logic [8:0] addr, input logic alsoUpdate);
        int busy;
        int page;
        int col;
        applyStimulus(1'b1, ascii, addr, alsoUpdate, 1'b0);
        busy = 0;
        @(negedge clk);
        checkOutput("upd_ready_during_write", 32'(update_ready), 32'd0);
        while (write_ready !== 1'b1 && busy < 20) begin
            if (busy < 8) checkOutput("font_addr", 32'(font_addr), 32'({ascii, 3'(busy)}));
            busy++;
            @(negedge clk);
        end
        checkOutput("write_busy_cycles", 32'(busy), 32'd9);
        page = int'(addr) / COLS;
        col  = int'(addr) % COLS;
        for (int c = 0; c < 8; c++) begin
            model[page*COLS + (col + c) % COLS] = 8'((int'(ascii) * 8 + c) % 256);
        end
    endtask

    task automatic checkStream(input logic clr);
        logic [8:0] expQ [$];
        for (int p = 0; p < PAGES; p++) begin
            expQ.push_back({1'b0, 8'(8'hB0 + p)});
            expQ.push_back({1'b0, 8'h00});
            expQ.push_back({1'b0, 8'h10});
            for (int i = 0; i < COLS; i++) begin
                expQ.push_back({1'b1, dataExp(clr ? 8'h00 : model[p*COLS + i])});
            end
        end
        checkOutput("upd_byte_count", 32'(capQ.size()), 32'(UPD_BYTES));
        for (int i = 0; i < UPD_BYTES && i < capQ.size(); i++) begin
            checkOutput($sformatf("upd_byte%0d", i), 32'(capQ[i]), 32'(expQ[i]));
        end
        checkOutput("dc_held_per_byte", 32'(dcHoldErrs), 32'd0);
    endtask

    task automatic doUpdate(input logic clr);
        int busy;
        capQ.delete();
        dcHoldErrs = 0;
        applyStimulus(1'b0, 8'h00, 9'h000, 1'b1, clr);
        busy = 0;
        @(negedge clk);
        while (update_ready !== 1'b1 && busy < UPD_CYCLES + 100) begin
            busy++;
            @(negedge clk);
        end
        checkOutput("upd_busy_cycles", 32'(busy), 32'(UPD_CYCLES));
        checkOutput("sclk_idle_low", 32'(oled_sclk), 32'd0);
        checkStream(clr);
    endtask

    initial begin
        int guard;
        int rises;
        for (int i = 0; i < PAGES*COLS; i++) model[i] = 8'h00;

        // Asynchronous reset applied mid-cycle, then held with a request pending.
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_write_ready", 32'(write_ready), 32'd1);
        checkOutput("rst_update_ready", 32'(update_ready), 32'd1);
        checkOutput("rst_sclk", 32'(oled_sclk), 32'd0);
        checkOutput("rst_sdin", 32'(oled_sdin), 32'd0);
        checkOutput("rst_dc", 32'(oled_dc), 32'd0);
        checkOutput("rst_font_addr", 32'(font_addr), 32'd0);
        write_start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_hold_ready", 32'({write_ready, update_ready}), 32'd3);
        checkOutput("rst_hold_spi", 32'({oled_sclk, oled_sdin, oled_dc}), 32'd0);
        checkOutput("rst_hold_font", 32'(font_addr), 32'd0);
        @(negedge clk);
        write_start = 1'b0;
        rst = 1'b0;

        $display("[TB] filling buffer with random characters");
        for (int p = 0; p < PAGES; p++) begin
            for (int k = 0; k < COLS/8; k++) begin
                doWrite(8'($urandom_range(0, 255)), 9'(p*COLS + k*8), 1'b0);
            end
        end

        doWrite(8'h41, 9'h008, 1'b0);
        doUpdate(1'b0);
        for (int k = 0; k < 8; k++) begin
            if (capQ.size() > 3 + 8 + k)
                checkOutput($sformatf("ascii41_col%0d", 8 + k), 32'(capQ[3 + 8 + k]), 32'({1'b1, dataExp(8'(8 + k))}));
        end

        $display("[TB] clear update");
        doUpdate(1'b1);

        $display("[TB] simultaneous write and update requests");
        rises = sclkRises;
        doWrite(8'h55, 9'h140, 1'b1);
        repeat (40) @(negedge clk);
        checkOutput("no_sclk_after_dual", 32'(sclkRises), 32'(rises));
        checkOutput("dual_update_ready", 32'(update_ready), 32'd1);

        $display("[TB] random and wrapping writes");
        for (int n = 0; n < 6; n++) begin
            doWrite(8'($urandom_range(0, 255)), 9'($urandom_range(0, 511)), 1'b0);
        end
        doWrite(8'h7F, 9'h07C, 1'b0);
        doUpdate(1'b0);
        if (capQ.size() > 3 + 124) begin
            checkOutput("wrap_col124", 32'(capQ[3 + 124]), 32'({1'b1, dataExp(8'hF8)}));
            checkOutput("wrap_col0", 32'(capQ[3]), 32'({1'b1, dataExp(8'hFC)}));
        end

        $display("[TB] reset during page 2 data");
        capQ.delete();
        applyStimulus(1'b0, 8'h00, 9'h000, 1'b1, 1'b0);
        guard = 0;
        while ((capQ.size() < 2*PAGE_BYTES + 8 || oled_sclk !== 1'b1) && guard < UPD_CYCLES) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reached_page2_data", 32'(guard < UPD_CYCLES), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_sclk", 32'(oled_sclk), 32'd0);
        checkOutput("abort_dc", 32'(oled_dc), 32'd0);
        checkOutput("abort_ready", 32'({write_ready, update_ready}), 32'd3);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        doUpdate(1'b0);
        if (capQ.size() > 0)
            checkOutput("restart_first_byte", 32'(capQ[0]), 32'({1'b0, 8'hB0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
